// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, with back-to-back frame support.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [6:0]       bits_left
);

`ifdef PISO_PARITY_EN
  localparam int unsigned F = WIDTH + 1;
`else
  localparam int unsigned F = WIDTH;
`endif
  localparam logic [6:0] FLEN = 7'(F);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [F-1:0]   shreg;
  logic [F-1:0]   frame;
  logic           accept;

  always_comb begin
    frame = '0;
`ifdef PISO_PARITY_EN
    frame = {data_in, ^data_in};
`else
    frame = data_in;
`endif
  end

  // Ready on the last bit lets the next frame follow with no idle gap.
  assign ready  = (state == IDLE) || (bits_left == 7'd1);
  assign accept = load && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      bits_left  <= '0;
    end else if (accept) begin
      // The MSB goes straight to dout; shreg holds the bits still to come.
      state      <= SHIFT;
      dout       <= frame[F-1];
      shreg      <= frame << 1;
      dout_valid <= 1'b1;
      bits_left  <= FLEN;
      done       <= (FLEN == 7'd1);
    end else if (state == SHIFT && bits_left > 7'd1) begin
      dout       <= shreg[F-1];
      shreg      <= shreg << 1;
      bits_left  <= bits_left - 7'd1;
      done       <= (bits_left == 7'd2);
    end else begin
      state      <= IDLE;
      shreg      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      bits_left  <= '0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=32 and WIDTH=1 instances).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int unsigned F = 33;
`else
  localparam int unsigned F = 32;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready, dout, dout_valid, done;
  logic [6:0]  bits_left;

  logic        load1 = 1'b0;
  logic [0:0]  d1 = '0;
  logic        ready1, dout1, dout_valid1, done1;
  logic [6:0]  bits_left1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .ready(ready), .dout(dout), .dout_valid(dout_valid),
    .done(done), .bits_left(bits_left)
  );

  piso_serializer #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .data_in(d1),
    .ready(ready1), .dout(dout1), .dout_valid(dout_valid1),
    .done(done1), .bits_left(bits_left1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [31:0] d, input int unsigned i);
    logic [31:0] v;
    v = d;
    if (i < 32) return v[31 - i];
    return ^v;
  endfunction

  task automatic check_idle(input string name);
    checks++;
    if (dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 ||
        bits_left !== 7'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: dout=%b valid=%b done=%b bits_left=%0d ready=%b, want 0 0 0 0 1",
               name, dout, dout_valid, done, bits_left, ready);
    end
  endtask

  task automatic check_bit(input string name, input int unsigned i, input logic eb,
                           input logic [6:0] ebl, input logic elast);
    checks++;
    if (dout !== eb || dout_valid !== 1'b1 || bits_left !== ebl ||
        done !== elast || ready !== elast) begin
      errors++;
      $display("FAIL %s bit %0d: dout=%b valid=%b bits_left=%0d done=%b ready=%b, want %b 1 %0d %b %b",
               name, i, dout, dout_valid, bits_left, done, ready, eb, ebl, elast, elast);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b1;
    data_in = 32'hFFFF_FFFF;
    load1 = 1'b1;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    load  = 1'b0;
    load1 = 1'b0;
    checks++;
    if (dout_valid1 !== 1'b0 || bits_left1 !== 7'd0 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w1: valid=%b bits_left=%0d ready=%b, want 0 0 1",
               dout_valid1, bits_left1, ready1);
    end
    tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_frame(input logic [31:0] d, input string name);
    data_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    data_in = ~d;
    for (int unsigned i = 0; i < F; i++) begin
      check_bit(name, i, exp_bit(d, i), 7'(F - i), i == F - 1);
      if (i != F - 1) tick();
    end
    tick();
    check_idle({name, "_end"});
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = 32'hFFFF0000;
    b = 32'h0000FFFF;
    data_in = a;
    load = 1'b1;
    tick();
    load = 1'b0;
    data_in = 32'h12345678;
    for (int unsigned i = 0; i < 2 * F; i++) begin
      if (i < F) check_bit("b2b", i, exp_bit(a, i), 7'(F - i), i == F - 1);
      else       check_bit("b2b", i, exp_bit(b, i - F), 7'(2 * F - i), i == 2 * F - 1);
      if (i == F - 1) begin
        data_in = b;
        load = 1'b1;
      end else begin
        load = 1'b0;
        data_in = 32'h12345678;
      end
      if (i != 2 * F - 1) tick();
    end
    load = 1'b0;
    tick();
    check_idle("b2b_end");
  endtask

  task automatic test_ignored_load();
    logic [31:0] a;
    a = 32'hAAAAAAAA;
    data_in = a;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int unsigned i = 0; i < F; i++) begin
      check_bit("ignored", i, exp_bit(a, i), 7'(F - i), i == F - 1);
      if (i == 4) begin
        data_in = 32'h12345678;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (i != F - 1) tick();
    end
    tick();
    check_idle("ignored_end");
  endtask

  task automatic test_reset_midframe();
    logic [31:0] a;
    a = 32'h5B66D96C;
    data_in = a;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      check_bit("midreset", i, exp_bit(a, i), 7'(F - i), 1'b0);
      if (i == 9) begin
        reset = 1'b1;
        load = 1'b1;
      end else begin
        tick();
      end
    end
    tick();
    reset = 1'b0;
    load = 1'b0;
    check_idle("midreset_abort");
    test_frame(a, "after_reset");
  endtask

  task automatic test_width1();
`ifndef PISO_PARITY_EN
    logic seq [6];
    seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    d1 = seq[0];
    load1 = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (dout1 !== seq[k] || dout_valid1 !== 1'b1 || done1 !== 1'b1 ||
          ready1 !== 1'b1 || bits_left1 !== 7'd1) begin
        errors++;
        $display("FAIL width1 cycle %0d: dout=%b valid=%b done=%b ready=%b bits_left=%0d, want %b 1 1 1 1",
                 k, dout1, dout_valid1, done1, ready1, bits_left1, seq[k]);
      end
      if (k < 5) d1 = seq[k + 1];
      else load1 = 1'b0;
    end
    tick();
    checks++;
    if (dout_valid1 !== 1'b0 || dout1 !== 1'b0 || bits_left1 !== 7'd0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL width1_end: valid=%b dout=%b bits_left=%0d done=%b, want 0 0 0 0",
               dout_valid1, dout1, bits_left1, done1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame(32'h5B66D96C, "frame_5b66");
    test_frame(32'h00000001, "frame_0001");
    test_back_to_back();
    test_ignored_load();
    test_reset_midframe();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 32, number of data bits per frame; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 load  input  1  request to accept data_in as a new frame.
REQ-005 data_in  input  WIDTH  parallel word to serialize, MSB transmitted first.
REQ-006 ready  output  1  block can accept a load this cycle.
REQ-007 dout  output  1  serial data bit, registered; the feed to the downstream sequence detector's din.
REQ-008 dout_valid  output  1  dout carries a frame bit this cycle, registered.
REQ-009 done  output  1  one-cycle pulse coinciding with the final bit of a frame.
REQ-010 bits_left  output  7  bits remaining in the current frame including the one on dout; 0 when idle.

Function
REQ-011 States: IDLE (no frame) and SHIFT (frame in progress); the block SHALL hold no other states.
REQ-012 Frame length F = WIDTH, or WIDTH+1 when parity is enabled (REQ-026).
REQ-013 Handshake: load is accepted only on a rising edge where load=1 and ready=1; a load with ready=0 is ignored with no side effects.
REQ-014 ready = 1 in IDLE, and 1 in SHIFT only while bits_left=1 (last bit); otherwise 0.
REQ-015 On acceptance, data_in is captured into an internal shift register and the state is SHIFT on the next cycle.
REQ-016 Latency: the first bit (data_in[WIDTH-1]) SHALL appear on dout with dout_valid=1 in the cycle after the accepting edge.
REQ-017 In SHIFT, dout advances one bit per cycle, MSB to LSB; dout_valid stays 1 for exactly F consecutive cycles per frame.
REQ-018 bits_left = F in the first bit cycle, decrementing by 1 per cycle down to 1 on the last bit.
REQ-019 done = 1 only in the cycle where bits_left=1; it is 0 in every other cycle.
REQ-020 Back-to-back: a load accepted during the last bit cycle starts the next frame in the immediately following cycle, with no idle gap and dout_valid held at 1.
REQ-021 No new load on the last bit: the next cycle enters IDLE with dout=0, dout_valid=0, bits_left=0.
REQ-022 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-023 WIDTH=1 boundary: every frame is a single cycle with done=1 and ready=1 in that cycle.

Reset
REQ-024 While reset=1 at a rising edge: state=IDLE, dout=0, dout_valid=0, done=0, bits_left=0, shift register cleared; ready=1 the cycle after.
REQ-025 Reset asserted mid-frame aborts the frame immediately; the remaining bits are discarded, and a load in the same cycle as reset is ignored.

Configuration
REQ-026 Macro PISO_PARITY_EN: when defined, F=WIDTH+1 and one even-parity bit (XOR of all WIDTH captured bits) is transmitted after the LSB, with done on the parity bit; when undefined, F=WIDTH and no parity bit is sent.

Verification
REQ-027 Reset 2 cycles, then load=1 with data_in=32'h5B66D96C, parity off -> dout over the next 32 cycles = 0101_1011_0110_0110_1101_1001_0110_1100, with done and ready high only on cycle 32, then dout_valid=0.
REQ-028 Load 32'hFFFF0000, then load 32'h0000FFFF during its last bit -> 64 contiguous dout_valid=1 cycles: 16 ones, 32 zeros, 16 ones; done pulses at cycles 32 and 64.
REQ-029 Load 32'hAAAAAAAA, then pulse load with data_in=32'h12345678 at bit 5 -> second load ignored, ready=0 at bit 5, frame completes as 32'hAAAAAAAA, then IDLE.
REQ-030 Load 32'h5B66D96C and assert reset on bit 10 -> next cycle dout=0, dout_valid=0, bits_left=0, ready=1; a fresh load then starts a full 32-bit frame.
REQ-031 PISO_PARITY_EN defined: load 32'h5B66D96C -> 33 bits with parity bit 0; load 32'h00000001 -> 33rd bit 1; done on bit 33 only.
REQ-032 WIDTH=1, hold load=1 and toggle data_in each cycle -> dout_valid stays 1 continuously and dout follows data_in delayed by one cycle.
